viterbi_decoder: RTL and testbench
==================================

Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for a rate-1/2, constraint-length-3 convolutional code with generators G0=111 (octal 7) and G1=101 (octal 5).
- Recovers the data bit stream from 2-bit channel symbols that may contain bit errors.
- Sits after the paired convolutional encoder and the channel/error-injection stage in the tx/rx datapath.
- The encoder is specified here as its companion sub-module; it also serves as the bench reference model.

Parameters:
- TB_DEPTH, 24, survivor (register-exchange) history length in bits; sets decode latency.
- PM_W, 8, path-metric width in bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  when high, d_in is a valid channel symbol, consumed at this rising edge.
- d_in  input  2  channel symbol {c1,c0}; c1 is the G0 output, c0 is the G1 output.
- d_out  output  1  decoded data bit, registered.

Behaviour:
- Reset (rst low, asynchronous):
  - path metric of state 0 = 0; states 1..3 = 16.
  - all survivor histories = 0; d_out = 0; symbol count = 0.
- Trellis:
  - state S = {p0,p1}; p0 = most recent previous data bit, p1 = the one before.
  - Input bit d moves S={p0,p1} to S'={d,p0}.
  - Expected symbol: c1 = d^p0^p1, c0 = d^p1.
- Branch metric: Hamming distance (0..2) between d_in and the expected symbol.
- ACS, each enabled cycle, per state S'={d,p0}:
  - candidates are predecessors {p0,0} and {p0,1}, each as metric + branch metric.
  - keep the smaller; on a tie choose p1=0.
  - new survivor history = predecessor history shifted left by 1, with d appended as LSB.
- Normalization: after ACS, if all four new metrics are ≥ 64, subtract 64 from each. Metrics never wrap.
- Output:
  - On an enabled edge consuming symbol k (k counted from 0 after reset), d_out is loaded with the oldest bit (bit TB_DEPTH-1) of the pre-update history of the minimum-metric state.
  - Minimum-state tie goes to the lowest index.
  - This makes d_out the estimate of data bit k-TB_DEPTH. It is 0 while k < TB_DEPTH.
- enable low: metrics, histories and d_out hold.
- Correction: for a clean stream, d_out reproduces the encoder input delayed by exactly TB_DEPTH enabled symbols. Isolated error bursts of ≤2 flipped bits separated by ≥12 clean symbols are fully corrected.
- Reset mid-stream: immediate return to reset state; decoding restarts from state 0 with the next enabled symbol.

Decomposition:
- Package viterbi_pkg holds:
  - constants G0=3'b111, G1=3'b101, K=3, NSTATES=4, PM_INIT=16, NORM_STEP=64.
  - a function returning the expected 2-bit symbol for (state, d).
- Sub-module conv_encoder:
  - ports clk, rst, enable_i (1), d_in (1), valid_o (1), d_out (2).
  - On each edge with enable_i high: d_out <= {d_in^p0^p1, d_in^p1}, then p1 <= p0, p0 <= d_in.
  - valid_o <= enable_i (one-cycle delay).
  - Registers hold while enable_i is low.
  - Reset clears p0, p1, d_out and valid_o to 0.

Test Plan:
- Reset: assert rst low mid-cycle -> d_out=0 immediately; encoder d_out=00, valid_o=0.
- Encoder vector: inputs 1,0,1,1,0,0 from reset with enable_i=1 -> d_out sequence 11,10,00,01,01,11; valid_o high one cycle after enable_i.
- Clean loopback, 300 random bits through encoder into decoder (decoder enable = encoder valid_o registered once; symbol registered once) -> d_out equals the input stream delayed by TB_DEPTH symbols, 0 mismatches.
- Error injection: flip c1 on symbols whose count mod 16 is 14 or 15, for the first 256 symbols -> 0 decoded bit errors.
- Enable gaps: deassert enable for 3 cycles every 10 symbols -> d_out holds during gaps; decoded stream still matches with 0 errors.
- Reset mid-stream after 100 symbols, then resume a new stream -> first TB_DEPTH outputs 0, then the new stream matches exactly.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the rate-1/2, K=3 (7,5) convolutional code.
package viterbi_pkg;

    localparam logic [2:0]  G0        = 3'b111;
    localparam logic [2:0]  G1        = 3'b101;
    localparam int unsigned K         = 3;
    localparam int unsigned NSTATES   = 1 << (K - 1);
    localparam int unsigned PM_INIT   = 16;
    localparam int unsigned NORM_STEP = 64;

    // state = {p0,p1}; returns {c1,c0} for input bit d leaving that state
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic d);
        logic [2:0] sr;
        sr = {d, state};
        return {^(sr & G0), ^(sr & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Channel-symbol bus between the receive datapath and the Viterbi decoder.
interface viterbi_decoder_if;

    logic       enable;
    logic [1:0] d_in;
    logic       d_out;

    modport master (output enable, output d_in, input d_out);
    modport slave  (input enable, input d_in, output d_out);

endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5); companion to viterbi_decoder.
module conv_encoder
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       valid_o,
    output logic [1:0] d_out
);

    logic p0;
    logic p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0      <= 1'b0;
            p1      <= 1'b0;
            d_out   <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= enable_i;
            if (enable_i) begin
                d_out <= exp_sym({p0, p1}, d_in);
                p1    <= p0;
                p0    <= d_in;
            end
        end
    end

endmodule

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select with metric normalization for the four-state trellis (combinational).
module viterbi_decoder_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = 8
) (
    input  logic [1:0]                    sym,
    input  logic [NSTATES-1:0][PM_W-1:0] pm,
    output logic [NSTATES-1:0][PM_W-1:0] pm_nxt,
    output logic [NSTATES-1:0]            sel
);

    logic [NSTATES-1:0][PM_W-1:0] pm_acs;
    logic [1:0]                   sv;
    logic [1:0]                   pa;
    logic [1:0]                   pb;
    logic [PM_W-1:0]              ca;
    logic [PM_W-1:0]              cb;
    logic                         all_big;

    always_comb begin
        pm_acs  = '0;
        pm_nxt  = '0;
        sel     = '0;
        sv      = '0;
        pa      = '0;
        pb      = '0;
        ca      = '0;
        cb      = '0;
        all_big = 1'b1;

        // Target state {d,p0} is reached from {p0,0} or {p0,1}; ties keep p1=0
        for (int unsigned s = 0; s < NSTATES; s++) begin
            sv = 2'(s);
            pa = {sv[0], 1'b0};
            pb = {sv[0], 1'b1};
            ca = pm[pa] + PM_W'(hamming2(sym, exp_sym(pa, sv[1])));
            cb = pm[pb] + PM_W'(hamming2(sym, exp_sym(pb, sv[1])));
            if (cb < ca) begin
                pm_acs[s] = cb;
                sel[s]    = 1'b1;
            end else begin
                pm_acs[s] = ca;
                sel[s]    = 1'b0;
            end
        end

        for (int unsigned s = 0; s < NSTATES; s++) begin
            if (pm_acs[s] < PM_W'(NORM_STEP)) begin
                all_big = 1'b0;
            end
        end

        for (int unsigned s = 0; s < NSTATES; s++) begin
            pm_nxt[s] = all_big ? pm_acs[s] - PM_W'(NORM_STEP) : pm_acs[s];
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the (7,5) K=3 code.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 24,
    parameter int unsigned PM_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    viterbi_decoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);

    logic [NSTATES-1:0][PM_W-1:0]     pm;
    logic [NSTATES-1:0][PM_W-1:0]     pm_nxt;
    logic [NSTATES-1:0][TB_DEPTH-1:0] hist;
    logic [NSTATES-1:0][TB_DEPTH-1:0] hist_nxt;
    logic [NSTATES-1:0]               sel;
    logic [CNT_W-1:0]                 sym_cnt;
    logic [1:0]                       best;
    logic [1:0]                       sv;
    logic [1:0]                       pred;
    logic                             bit_nxt;
    logic                             d_out_q;

    viterbi_decoder_acs #(
        .PM_W(PM_W)
    ) u_acs (
        .sym    (bus.d_in),
        .pm     (pm),
        .pm_nxt (pm_nxt),
        .sel    (sel)
    );

    always_comb begin
        hist_nxt = '0;
        sv       = '0;
        pred     = '0;
        for (int unsigned s = 0; s < NSTATES; s++) begin
            sv          = 2'(s);
            pred        = {sv[0], sel[s]};
            hist_nxt[s] = {hist[pred][TB_DEPTH-2:0], sv[1]};
        end
    end

    // Output decision uses the pre-update metrics and histories; lowest index wins ties
    always_comb begin
        best = '0;
        for (int unsigned s = 1; s < NSTATES; s++) begin
            if (pm[s] < pm[best]) begin
                best = 2'(s);
            end
        end
        bit_nxt = (sym_cnt == CNT_W'(TB_DEPTH)) ? hist[best][TB_DEPTH-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < NSTATES; s++) begin
                pm[s] <= (s == 0) ? '0 : PM_W'(PM_INIT);
            end
            hist    <= '0;
            sym_cnt <= '0;
            d_out_q <= 1'b0;
        end else if (bus.enable) begin
            pm      <= pm_nxt;
            hist    <= hist_nxt;
            d_out_q <= bit_nxt;
            if (sym_cnt != CNT_W'(TB_DEPTH)) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Encoder-to-decoder loopback bench with a scoreboard of delayed data bits.
module tb_viterbi_decoder;

    localparam int unsigned TB_DEPTH = 24;

    typedef struct {
        logic       d;
        logic [1:0] sym;
    } enc_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_en;
    logic       enc_d;
    logic       enc_valid;
    logic [1:0] enc_sym;

    int         checks = 0;
    int         fails  = 0;
    int         pops   = 0;
    int         sent   = 0;
    int         sym_idx;
    bit         chk_on = 1'b0;
    bit         inj_on = 1'b0;
    logic       took;
    logic       last_exp = 1'b0;
    logic       e;
    logic       exp_q[$];
    enc_vec_t   tbl[6];

    viterbi_decoder_if dbus ();

    viterbi_decoder #(
        .TB_DEPTH (TB_DEPTH),
        .PM_W     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dbus)
    );

    conv_encoder enc (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enc_en),
        .d_in     (enc_d),
        .valid_o  (enc_valid),
        .d_out    (enc_sym)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Channel stage: register the encoder output once, optionally flipping c1
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus.enable <= 1'b0;
            dbus.d_in   <= 2'b00;
            sym_idx     <= 0;
        end else begin
            dbus.enable <= enc_valid;
            if (enc_valid) begin
                if (inj_on && sym_idx < 256 && (sym_idx % 16) >= 14)
                    dbus.d_in <= enc_sym ^ 2'b10;
                else
                    dbus.d_in <= enc_sym;
                sym_idx <= sym_idx + 1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) took <= 1'b0;
        else      took <= dbus.enable;
    end

    always @(negedge clk) begin
        if (rst && chk_on) begin
            if (took) begin
                if (exp_q.size() == 0) begin
                    check("dec_queue_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_out", {31'd0, dbus.d_out}, {31'd0, e});
                    last_exp = e;
                    pops++;
                end
            end else begin
                check("dec_hold", {31'd0, dbus.d_out}, {31'd0, last_exp});
            end
        end
    end

    task automatic restart(input bit inject);
        chk_on = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_dec_out", {31'd0, dbus.d_out}, 0);
        check("rst_enc_sym", {30'd0, enc_sym}, 0);
        check("rst_enc_valid", {31'd0, enc_valid}, 0);
        exp_q.delete();
        for (int i = 0; i < int'(TB_DEPTH); i++) exp_q.push_back(1'b0);
        last_exp = 1'b0;
        pops     = 0;
        sent     = 0;
        inj_on   = inject;
        @(posedge clk);
        #2 rst = 1'b1;
        chk_on = 1'b1;
    endtask

    task automatic send_stream(input int n, input bit gaps, input bit ones);
        logic b;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && (i % 10) == 0) begin
                enc_en = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            b = ones ? 1'b1 : 1'($urandom_range(0, 1));
            enc_en = 1'b1;
            enc_d  = b;
            exp_q.push_back(b);
            sent++;
            @(posedge clk);
            #1;
        end
        enc_en = 1'b0;
    endtask

    task automatic finish_stream();
        repeat (4) @(posedge clk);
        #1;
        check("dec_symbols_consumed", pops, sent);
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'b11};
        tbl[1] = '{1'b0, 2'b10};
        tbl[2] = '{1'b1, 2'b00};
        tbl[3] = '{1'b1, 2'b01};
        tbl[4] = '{1'b0, 2'b01};
        tbl[5] = '{1'b0, 2'b11};

        rst    = 1'b0;
        enc_en = 1'b0;
        enc_d  = 1'b0;

        restart(1'b0);
        check("enc_valid_idle", {31'd0, enc_valid}, 0);
        for (int i = 0; i < 6; i++) begin
            enc_en = 1'b1;
            enc_d  = tbl[i].d;
            exp_q.push_back(tbl[i].d);
            sent++;
            @(posedge clk);
            #1;
            check("enc_sym", {30'd0, enc_sym}, {30'd0, tbl[i].sym});
            check("enc_valid", {31'd0, enc_valid}, 1);
        end
        enc_en = 1'b0;
        @(posedge clk);
        #1;
        check("enc_valid_drop", {31'd0, enc_valid}, 0);
        check("enc_sym_hold", {30'd0, enc_sym}, {30'd0, tbl[5].sym});
        finish_stream();

        restart(1'b0);
        send_stream(300, 1'b0, 1'b0);
        finish_stream();

        restart(1'b1);
        send_stream(280, 1'b0, 1'b0);
        finish_stream();

        restart(1'b0);
        send_stream(200, 1'b1, 1'b0);
        finish_stream();

        restart(1'b0);
        send_stream(70, 1'b0, 1'b0);
        send_stream(30, 1'b0, 1'b1);
        restart(1'b0);
        send_stream(150, 1'b0, 1'b0);
        finish_stream();

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
